// File: rtl/dma_desc_sched_pkg.sv
// dma_sched_pkg: shared constants and helpers for the DMA descriptor scheduler
package dma_sched_pkg;
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int REQ_PREFETCH = 0;
  localparam int REQ_HOST = 1;
  localparam int REQ_EVICT = 2;
  localparam int FLAG_RD = 0;
  localparam int FLAG_COMP = 1;
  localparam int FLAG_PREFETCH = 2;
endpackage

// File: rtl/dma_desc_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick over a request vector; search starts at the stored pointer
module rr_arbiter import dma_sched_pkg::*; #(
  parameter int N = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             i_req,
  input  logic                     i_en,
  output logic                     o_any,
  output logic [id_width(N)-1:0]   o_idx
);
  localparam int IW = id_width(N);
  logic [IW-1:0] r_ptr, w_j;
  // first requester at or after the pointer, wrapping around
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(r_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_idx = w_j;
        o_any = 1'b1;
      end
    end
  end
  // pointer moves just past the winner only when this class is granted
  always_ff @(posedge clk) begin
    if (!rst_n) r_ptr <= '0;
    else if (i_en && o_any) r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + IW'(1);
  end
endmodule

// File: rtl/dma_desc_sched.sv
// dma_desc_sched: arbitrates requesters into one descriptor slot and routes completions back
module dma_desc_sched import dma_sched_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int DESC_WIDTH = 128,
  parameter int MAX_OUTSTANDING = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_enable,
  input  logic [NUM_REQ-1:0]                cfg_prio_mask,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DESC_WIDTH-1:0]     req_desc,
  output logic                              desc_valid,
  input  logic                              desc_ready,
  output logic [DESC_WIDTH-1:0]             desc_data,
  input  logic                              done_valid,
  output logic                              cpl_valid,
  output logic [id_width(NUM_REQ)-1:0]      cpl_id,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              idle,
  output logic                              err_underflow
);
  localparam int IW = id_width(NUM_REQ);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [OW-1:0] r_out;
  logic r_dv, r_cpl_valid, r_err;
  logic [DESC_WIDTH-1:0] r_data;
  logic [IW-1:0] r_slot_id, r_cpl_id;
  logic [SW-1:0] r_starve;
  logic [IW-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wp, r_rp;
  logic [NUM_REQ-1:0] w_hi, w_lo;
  logic w_pick_lo, w_grant, w_issue, w_pop, w_hi_any, w_lo_any;
  logic [IW-1:0] w_hi_idx, w_lo_idx, w_gidx;
  logic [DESC_WIDTH-1:0] w_desc;
  assign w_hi = req_valid & cfg_prio_mask;
  assign w_lo = req_valid & ~cfg_prio_mask;
  assign w_pick_lo = w_lo_any && (r_starve == SW'(STARVE_LIMIT) || !w_hi_any);
  assign w_gidx = w_pick_lo ? w_lo_idx : w_hi_idx;
  // the descriptor waiting in the slot counts against the limit so it can never overflow
  assign w_grant = rst_n && cfg_enable && (!r_dv || desc_ready) &&
                   ((r_out + OW'(r_dv)) < OW'(MAX_OUTSTANDING)) && (|req_valid);
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
  assign w_issue = r_dv && desc_ready;
  assign w_pop = done_valid && (r_out != '0);
  assign desc_valid = r_dv;
  assign desc_data = r_data;
  assign cpl_valid = r_cpl_valid;
  assign cpl_id = r_cpl_id;
  assign outstanding = r_out;
  assign idle = (r_out == '0) && !r_dv;
  assign err_underflow = r_err;
  rr_arbiter #(.N(NUM_REQ)) u_hi (
    .clk(clk), .rst_n(rst_n), .i_req(w_hi), .i_en(w_grant && !w_pick_lo),
    .o_any(w_hi_any), .o_idx(w_hi_idx)
  );
  rr_arbiter #(.N(NUM_REQ)) u_lo (
    .clk(clk), .rst_n(rst_n), .i_req(w_lo), .i_en(w_grant && w_pick_lo),
    .o_any(w_lo_any), .o_idx(w_lo_idx)
  );
  // select the granted requester's descriptor slice
  always_comb begin
    w_desc = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_gidx == IW'(i)) w_desc = req_desc[i*DESC_WIDTH +: DESC_WIDTH];
  end
  // output slot: load on grant, hold until the engine accepts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dv <= 1'b0;
      r_data <= '0;
      r_slot_id <= '0;
    end else if (w_grant) begin
      r_dv <= 1'b1;
      r_data <= w_desc;
      r_slot_id <= w_gidx;
    end else if (desc_ready) r_dv <= 1'b0;
  end
  // count high-class wins while low class waits; any low grant or empty low class clears it
  always_ff @(posedge clk) begin
    if (!rst_n || !w_lo_any || (w_grant && w_pick_lo)) r_starve <= '0;
    else if (w_grant && r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + SW'(1);
  end
  // in-order ID FIFO storage
  always_ff @(posedge clk) begin
    if (w_issue) r_fifo[r_wp] <= r_slot_id;
  end
  // FIFO pointers, outstanding count, completion routing and sticky underflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_out <= '0;
      r_cpl_valid <= 1'b0;
      r_cpl_id <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_issue) r_wp <= r_wp + PW'(1);
      if (w_pop) begin
        r_rp <= r_rp + PW'(1);
        r_cpl_id <= r_fifo[r_rp];
      end
      r_cpl_valid <= w_pop;
      r_out <= r_out + OW'(w_issue) - OW'(w_pop);
      r_err <= r_err | (done_valid && r_out == '0);
    end
  end
endmodule

// File: tb/tb_dma_desc_sched.sv
// tb_dma_desc_sched: scoreboard bench with a queue-based reference model of the scheduler
module tb_dma_desc_sched;
  import dma_sched_pkg::*;
  localparam int N = 3, DW = 128, MAX = 16, SL = 4, IW = id_width(N), OW = $clog2(MAX) + 1;
  logic clk = 0, rst_n = 0, cfg_enable = 0, desc_ready = 0, done_valid = 0;
  logic [N-1:0] cfg_prio_mask = '0, req_valid = '0, req_ready;
  logic [N*DW-1:0] req_desc = '0;
  logic desc_valid, cpl_valid, idle, err_underflow;
  logic [DW-1:0] desc_data;
  logic [IW-1:0] cpl_id;
  logic [OW-1:0] outstanding;
  int checks = 0, failures = 0;
  int m_ptr[2];
  int m_starve = 0, m_slot_id = 0;
  bit m_pending = 0, m_err = 0, m_cpl_now = 0;
  int m_inflight[$];
  logic [DW-1:0] sb_desc[$];
  int sb_cpl[$];
  int glog[$];

  always #5 clk = ~clk;

  dma_desc_sched #(.NUM_REQ(N), .DESC_WIDTH(DW), .MAX_OUTSTANDING(MAX), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_prio_mask(cfg_prio_mask),
    .req_valid(req_valid), .req_ready(req_ready), .req_desc(req_desc),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .done_valid(done_valid), .cpl_valid(cpl_valid), .cpl_id(cpl_id),
    .outstanding(outstanding), .idle(idle), .err_underflow(err_underflow)
  );

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) if (v[(start + k) % N]) return (start + k) % N;
    return 0;
  endfunction

  // reference model: checks state-like outputs, predicts the grant, pushes expectations
  always @(negedge clk) begin
    logic [N-1:0] hi, lo, exp_rdy;
    bit can, plo;
    int g;
    check("desc_valid", desc_valid, m_pending);
    check("outstanding", outstanding, m_inflight.size());
    check("idle", idle, m_inflight.size() == 0 && !m_pending);
    check("err_underflow", err_underflow, m_err);
    check("cpl_valid", cpl_valid, m_cpl_now);
    if (!rst_n) begin
      check("req_ready_rst", req_ready, 0);
      m_ptr = '{0, 0};
      m_starve = 0; m_pending = 0; m_err = 0; m_cpl_now = 0; m_slot_id = 0;
      m_inflight.delete(); sb_desc.delete(); sb_cpl.delete();
    end else begin
      hi = req_valid & cfg_prio_mask;
      lo = req_valid & ~cfg_prio_mask;
      can = cfg_enable && (!m_pending || desc_ready) && (m_inflight.size() + int'(m_pending) < MAX) && (req_valid != 0);
      plo = (lo != 0) && (m_starve == SL || hi == 0);
      g = plo ? rr(lo, m_ptr[1]) : rr(hi, m_ptr[0]);
      exp_rdy = can ? (N'(1) << g) : '0;
      check("req_ready", req_ready, exp_rdy);
      m_cpl_now = 0;
      if (done_valid) begin
        if (m_inflight.size() > 0) begin
          sb_cpl.push_back(m_inflight.pop_front());
          m_cpl_now = 1;
        end else m_err = 1;
      end
      if (m_pending && desc_ready) m_inflight.push_back(m_slot_id);
      if (can) begin
        m_pending = 1;
        m_slot_id = g;
        sb_desc.push_back(req_desc[g*DW +: DW]);
        m_ptr[plo] = (g + 1) % N;
      end else if (desc_ready) m_pending = 0;
      if (lo == 0 || (can && plo)) m_starve = 0;
      else if (can) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
    end
  end

  // monitor: pops scoreboard entries whenever the DUT presents an output
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (req_ready != 0) glog.push_back($clog2(req_ready));
      if (desc_valid && desc_ready) begin
        checks++;
        if (sb_desc.size() == 0) begin
          failures++;
          $display("FAIL desc_issue: got %0h expected no issue", desc_data);
        end else if (desc_data !== sb_desc[0]) begin
          failures++;
          $display("FAIL desc_data: got %0h expected %0h", desc_data, sb_desc[0]);
        end
        if (sb_desc.size() != 0) void'(sb_desc.pop_front());
      end
      if (cpl_valid) begin
        checks++;
        if (sb_cpl.size() == 0) begin
          failures++;
          $display("FAIL cpl: got id %0d expected no completion", cpl_id);
        end else if (int'(cpl_id) != sb_cpl[0]) begin
          failures++;
          $display("FAIL cpl_id: got %0d expected %0d", cpl_id, sb_cpl[0]);
        end
        if (sb_cpl.size() != 0) void'(sb_cpl.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_desc();
    for (int i = 0; i < N*DW/32; i++) req_desc[i*32 +: 32] = $urandom();
  endtask

  task automatic do_reset();
    rst_n = 0; cfg_enable = 0; desc_ready = 0; done_valid = 0; req_valid = '0; cfg_prio_mask = '0;
    cyc();
    cyc();
    rst_n = 1;
    glog.delete();
  endtask

  task automatic cmp_log(input string nm, input int exp[$]);
    check({nm, "_len"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size(); i++) check(nm, glog[i], exp[i]);
  endtask

  initial begin
    int e[$];
    logic [DW-1:0] b;
    rst_n = 0;
    cyc();
    check("rst_desc_data", desc_data, 0);
    check("rst_cpl_id", cpl_id, 0);
    check("rst_idle", idle, 1);
    do_reset();
    // single requester, three descriptors then three completions
    cfg_enable = 1; desc_ready = 1; req_valid = 3'b001;
    repeat (3) begin rand_desc(); cyc(); end
    req_valid = '0;
    cyc(); cyc();
    check("single_out", outstanding, 3);
    done_valid = 1;
    repeat (3) cyc();
    done_valid = 0;
    cyc();
    check("single_out0", outstanding, 0);
    check("single_idle", idle, 1);
    // plain round robin
    do_reset();
    cfg_enable = 1; desc_ready = 1; req_valid = 3'b111;
    repeat (6) begin rand_desc(); cyc(); end
    req_valid = '0;
    cyc();
    e = '{0, 1, 2, 0, 1, 2};
    cmp_log("rr_order", e);
    // anti-starvation
    do_reset();
    cfg_enable = 1; desc_ready = 1; cfg_prio_mask = 3'b011; req_valid = 3'b111;
    repeat (10) begin rand_desc(); cyc(); end
    req_valid = '0;
    cyc();
    e = '{0, 1, 0, 1, 2, 0, 1, 0, 1, 2};
    cmp_log("starve_order", e);
    // outstanding limit
    do_reset();
    cfg_enable = 1; desc_ready = 1; req_valid = 3'b001;
    repeat (30) begin rand_desc(); cyc(); end
    check("limit_issues", glog.size(), 16);
    check("limit_out", outstanding, 16);
    done_valid = 1;
    cyc();
    done_valid = 0;
    repeat (5) cyc();
    check("limit_one_more", glog.size(), 17);
    check("limit_out2", outstanding, 16);
    // backpressure, then issue and done in the same cycle
    do_reset();
    cfg_enable = 1; desc_ready = 1; req_valid = 3'b001;
    rand_desc();
    cyc();
    rand_desc();
    b = req_desc[DW-1:0];
    cyc();
    glog.delete();
    desc_ready = 0; req_valid = 3'b111;
    repeat (5) begin
      rand_desc();
      cyc();
      check("bp_data", desc_data, b);
      check("bp_out", outstanding, 1);
    end
    check("bp_no_grant", glog.size(), 0);
    req_valid = '0; desc_ready = 1; done_valid = 1;
    cyc();
    done_valid = 0;
    check("simul_out", outstanding, 1);
    check("simul_cpl_valid", cpl_valid, 1);
    check("simul_cpl_id", cpl_id, 0);
    cyc();
    // underflow and mid-operation reset
    do_reset();
    done_valid = 1;
    cyc();
    done_valid = 0;
    check("uf_err", err_underflow, 1);
    check("uf_out", outstanding, 0);
    cyc();
    check("uf_no_cpl", cpl_valid, 0);
    check("uf_sticky", err_underflow, 1);
    cfg_enable = 1; desc_ready = 1; req_valid = 3'b111;
    repeat (7) begin rand_desc(); cyc(); end
    req_valid = '0;
    cyc();
    check("pre_rst_out", outstanding, 7);
    rst_n = 0;
    cyc();
    check("rst_out", outstanding, 0);
    check("rst_dv", desc_valid, 0);
    check("rst_err", err_underflow, 0);
    do_reset();
    // randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 499) == 0) rst_n = 0;
      else rst_n = 1;
      if ($urandom_range(0, 49) == 0) cfg_prio_mask = N'($urandom());
      cfg_enable = $urandom_range(0, 9) != 0;
      req_valid = N'($urandom());
      desc_ready = $urandom_range(0, 3) != 0;
      done_valid = m_inflight.size() > 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      rand_desc();
      cyc();
    end
    rst_n = 1; req_valid = '0; desc_ready = 1; done_valid = 0;
    for (int t = 0; t < 100 && (m_inflight.size() > 0 || m_pending); t++) begin
      done_valid = m_inflight.size() > 0;
      cyc();
    end
    done_valid = 0;
    cyc();
    cyc();
    check("drain_idle", idle, 1);
    check("sb_desc_empty", sb_desc.size(), 0);
    check("sb_cpl_empty", sb_cpl.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_desc_sched.md
Name: dma_desc_sched

Overview:
Descriptor scheduler in front of the CXL DMA engine's descriptor FIFO. It arbitrates among NUM_REQ requesters (prefetch core, host MMIO, eviction path) and issues one descriptor at a time into the engine's valid/ready port. It tracks issued descriptors in an in-order ID FIFO, so each engine done_valid pulse is routed back to the requester that issued it. It enforces an outstanding-descriptor limit and anti-starvation for low-priority requesters.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DESC_WIDTH, 128, descriptor width; passed through unmodified
MAX_OUTSTANDING, 16, max issued-but-not-completed descriptors (power of 2)
STARVE_LIMIT, 4, consecutive high-class grants allowed while a low-class requester waits (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_enable  in  1  1 = grants allowed; 0 = no new grants, in-flight work drains
cfg_prio_mask  in  NUM_REQ  bit i = 1 puts requester i in the high class
req_valid  in  NUM_REQ  per-requester descriptor valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_desc  in  NUM_REQ*DESC_WIDTH  requester i occupies slice [i*DESC_WIDTH +: DESC_WIDTH]
desc_valid  out  1  descriptor to engine valid
desc_ready  in  1  engine accepts
desc_data  out  DESC_WIDTH  descriptor to engine
done_valid  in  1  engine completion pulse, one per descriptor, in issue order
cpl_valid  out  1  completion to requester
cpl_id  out  $clog2(NUM_REQ)  requester index of completion
outstanding  out  $clog2(MAX_OUTSTANDING)+1  issued-not-completed count
idle  out  1  outstanding==0 && !desc_valid
err_underflow  out  1  sticky: done_valid received with ID FIFO empty

Behaviour:
- Reset values: req_ready=0, desc_valid=0, desc_data=0, cpl_valid=0, cpl_id=0, outstanding=0, err_underflow=0, idle=1. RR pointers=0, starve_cnt=0, ID FIFO empty.
- Output slot is a single register. slot_free = !desc_valid || desc_ready.
- Grant condition: cfg_enable && slot_free && (outstanding + desc_valid_pending) < MAX_OUTSTANDING && any req_valid. Count the pending slot descriptor against the limit so a full limit never overflows.
- req_ready is combinational and asserted only for the granted index in the same cycle. The accepted descriptor appears on desc_data/desc_valid next cycle (latency 1). desc_valid/desc_data stay stable until desc_ready.
- Arbitration is two-level. High class = req_valid & cfg_prio_mask; low class = req_valid & ~cfg_prio_mask. Within each class, round-robin starting after the last granted index of that class; the pointer advances only on a grant in that class.
- Class choice: if starve_cnt == STARVE_LIMIT and low class is non-empty, grant low; otherwise grant high if non-empty, else low.
- starve_cnt: +1 on a high grant while low class is non-empty (saturating at STARVE_LIMIT). Reset to 0 on any low grant or on any cycle with low class empty.
- Issue (desc_valid && desc_ready): push the requester ID into the ID FIFO and increment outstanding.
- done_valid: pop the ID FIFO. Next cycle cpl_valid=1 and cpl_id=popped ID; decrement outstanding.
- Simultaneous issue and done in one cycle: push and pop both occur; outstanding unchanged.
- done_valid with FIFO empty: no pop, no cpl_valid, outstanding held at 0, err_underflow set (cleared only by reset).
- cfg_enable deassert: the current slot still drains, completions still flow, no new req_ready.
- cfg_prio_mask change takes effect on the next arbitration cycle; RR pointers are retained.
- Reset mid-operation: all state cleared, in-flight IDs discarded. The engine is reset on the same rst_n.

Decomposition:
- Package dma_sched_pkg: requester ID width function, default requester index constants (REQ_PREFETCH=0, REQ_HOST=1, REQ_EVICT=2), flag bit positions (FLAG_RD=0, FLAG_COMP=1, FLAG_PREFETCH=2).
- One sub-module: rr_arbiter (masked round-robin over a request vector, with pointer-update enable), instantiated twice, once per class.
- The ID FIFO is inline.

Test Plan:
- Single requester: req0 sends 3 descriptors, desc_ready=1 -> desc_data matches in order at 1-cycle latency. After 3 done_valid pulses: cpl_id=0 three times, outstanding returns 0, idle=1.
- Round-robin: prio_mask=000, all three valid continuously -> grant order 0,1,2,0,1,2.
- Starvation: prio_mask=011, req0/req1/req2 valid, STARVE_LIMIT=4 -> grants 0,1,0,1,2,0,1,0,1,2.
- Limit: MAX_OUTSTANDING=16, no done_valid -> exactly 16 issues, then req_ready=0. One done_valid -> exactly one more issue, outstanding stays 16.
- Backpressure and simultaneity: desc_ready=0 for 5 cycles -> desc_data stable, no further req_ready. Issue and done in the same cycle -> outstanding unchanged, cpl_id correct.
- Error and reset: done_valid with outstanding=0 -> err_underflow=1, no cpl_valid. rst_n low with outstanding=7 -> outstanding=0, desc_valid=0, err_underflow=0.
